// File: rtl/led_status_arbiter.sv
// led_status_arbiter
//
// Shares the 4-bit front-panel LED bank between NUM_REQ status requesters.
// The lowest-index active requester wins. A new owner keeps the LEDs for at
// least MIN_HOLD_TICKS ticks so they do not flicker between owners. Each owner
// can show its pattern steady or blinking. With no requester active, the LEDs
// alternate 0xA / 0x5 as the idle indication.
//
// Ports:
//   clk_10MHz   - sole clock, rising edge
//   reset       - asynchronous, active-high reset
//   req         - per-requester request level (held while the LEDs are wanted)
//   req_pattern - 4-bit pattern per requester, requester i on [4i+3:4i]
//   req_blink   - per-requester blink enable (1 = blink, 0 = steady)
//   grant       - one-hot current owner, all zeros when idle (registered)
//   busy        - any grant active (registered)
//   led         - LED drive (registered)

module led_status_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned TICK_DIV         = 10000,
  parameter int unsigned MIN_HOLD_TICKS   = 500,
  parameter int unsigned BLINK_HALF_TICKS = 417
) (
  input  logic                   clk_10MHz,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_pattern,
  input  logic [NUM_REQ-1:0]     req_blink,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [3:0]             led
);

  // Counter widths sized to hold their terminal value; at least one bit.
  localparam int unsigned TickW  = (TICK_DIV > 1)         ? $clog2(TICK_DIV)         : 1;
  localparam int unsigned HoldW  = (MIN_HOLD_TICKS > 1)   ? $clog2(MIN_HOLD_TICKS)   : 1;
  localparam int unsigned BlinkW = (BLINK_HALF_TICKS > 1) ? $clog2(BLINK_HALF_TICKS) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(MIN_HOLD_TICKS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_TICKS - 1);

  localparam logic [3:0] LedIdleA = 4'hA;
  localparam logic [3:0] LedIdleB = 4'h5;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StOwn
  } state_e;

  // Registered state.
  state_e             state_q,     state_d;
  logic [TickW-1:0]   tick_cnt_q,  tick_cnt_d;
  logic [HoldW-1:0]   hold_cnt_q,  hold_cnt_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic               phase_q,     phase_d;
  logic [3:0]         pat_q,       pat_d;
  logic               blink_en_q,  blink_en_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic               busy_q,      busy_d;
  logic [3:0]         led_q,       led_d;

  // Combinational helpers.
  logic               tick;
  logic               blink_wrap;
  logic               any_req;
  logic               owner_req;
  logic               higher_req;
  logic [NUM_REQ-1:0] req_winner;
  logic               new_grant;
  logic [NUM_REQ-1:0] new_sel;
  logic               go_idle;

  // OR-select of the 4-bit pattern belonging to a one-hot requester vector.
  function automatic logic [3:0] pick_pattern(input logic [NUM_REQ-1:0]   sel,
                                              input logic [4*NUM_REQ-1:0] pats);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        p = p | pats[4*i +: 4];
      end
    end
    return p;
  endfunction

  // Free-running tick prescaler, never restarted by a grant.
  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Arbitration terms.
  always_comb begin
    any_req    = |req;
    // Isolate the lowest set bit: the highest-priority active requester.
    req_winner = req & (~req + 1'b1);
    owner_req  = |(req & grant_q);
    // For one-hot grant_q, grant_q - 1 masks every index below the owner.
    higher_req = |(req & (grant_q - 1'b1));
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    pat_d      = pat_q;
    blink_en_d = blink_en_q;
    new_grant  = 1'b0;
    new_sel    = '0;
    go_idle    = 1'b0;

    // Hold counter advances on ticks and saturates at its terminal value.
    hold_cnt_d = (tick && (hold_cnt_q != HoldLast)) ? hold_cnt_q + 1'b1 : hold_cnt_q;

    // Blink counter and phase run in every state; in idle the phase picks
    // 0xA / 0x5, while granted it gates a blinking pattern.
    blink_wrap  = tick && (blink_cnt_q == BlinkLast);
    if (tick) begin
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
    phase_d = blink_wrap ? ~phase_q : phase_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          new_grant = 1'b1;
          new_sel   = req_winner;
        end
      end

      StHold: begin
        // Preemption is ignored here; a dropped owner keeps its last pattern.
        if (owner_req) begin
          pat_d      = pick_pattern(grant_q, req_pattern);
          blink_en_d = |(grant_q & req_blink);
        end
        if (tick && (hold_cnt_q == HoldLast)) begin
          state_d = StOwn;
        end
      end

      StOwn: begin
        if (!owner_req && any_req) begin
          new_grant = 1'b1;
          new_sel   = req_winner;
        end else if (!owner_req) begin
          go_idle = 1'b1;
        end else if (higher_req) begin
          new_grant = 1'b1;
          new_sel   = req_winner;
        end else begin
          pat_d      = pick_pattern(grant_q, req_pattern);
          blink_en_d = |(grant_q & req_blink);
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // Any new grant restarts hold and blink timing with the pattern shown.
    if (new_grant) begin
      state_d     = StHold;
      grant_d     = new_sel;
      pat_d       = pick_pattern(new_sel, req_pattern);
      blink_en_d  = |(new_sel & req_blink);
      hold_cnt_d  = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end

    if (go_idle) begin
      state_d     = StIdle;
      grant_d     = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end

    busy_d = |grant_d;

    // LED drive computed from next-state values so it lands with the grant.
    if (state_d == StIdle) begin
      led_d = phase_d ? LedIdleB : LedIdleA;
    end else if (blink_en_d && phase_d) begin
      led_d = 4'h0;
    end else begin
      led_d = pat_d;
    end
  end

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pat_q       <= '0;
      blink_en_q  <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      led_q       <= LedIdleA;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pat_q       <= pat_d;
      blink_en_q  <= blink_en_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// tb_led_status_arbiter
//
// Scoreboard bench for led_status_arbiter with small timing parameters
// (TICK_DIV = 4, MIN_HOLD_TICKS = 3, BLINK_HALF_TICKS = 2). Inputs change on
// the falling edge; the expected outputs for the following rising edge are
// queued at the same time and compared 1 time unit after that edge.

module tb_led_status_arbiter;

  localparam int TickDiv = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_pattern;
  logic [3:0]  req_blink;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  led;

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  led_status_arbiter #(
    .NUM_REQ          (4),
    .TICK_DIV         (4),
    .MIN_HOLD_TICKS   (3),
    .BLINK_HALF_TICKS (2)
  ) dut (
    .clk_10MHz   (clk),
    .reset       (reset),
    .req         (req),
    .req_pattern (req_pattern),
    .req_blink   (req_blink),
    .grant       (grant),
    .busy        (busy),
    .led         (led)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; edges that are multiples of TickDiv
  // carry the prescaler tick.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic b,
                               input logic [3:0] l);
    check_eq({tag, ".grant"}, 32'(grant), 32'(g));
    check_eq({tag, ".busy"},  32'(busy),  32'(b));
    check_eq({tag, ".led"},   32'(led),   32'(l));
  endtask

  // Scoreboard consumer.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_outputs(mon_e.tag, mon_e.grant, mon_e.busy, mon_e.led);
    end
  end

  // Queue the expectation for the next rising edge, then move to the next
  // falling edge.
  task automatic expect_next(input string tag, input logic [3:0] g, input logic b,
                             input logic [3:0] l);
    exp_t e;
    e.tag   = tag;
    e.grant = g;
    e.busy  = b;
    e.led   = l;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leave the bench at a falling edge whose next rising edge carries a tick.
  task automatic align_tick();
    while ((edge_n % TickDiv) != (TickDiv - 1)) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    req         = '0;
    req_pattern = '0;
    req_blink   = '0;
    #1 reset = 1'b1;
    #1;
    check_outputs("reset_async", 4'b0000, 1'b0, 4'hA);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle indication: 0x5 after 8 edges, back to 0xA after 16.
    for (int k = 1; k <= 16; k++) begin
      expect_next($sformatf("idle_e%0d", k), 4'b0000, 1'b0,
                  ((k >= 8) && (k < 16)) ? 4'h5 : 4'hA);
    end

    // req[2], pattern 0x3, dropped after two cycles: held through HOLD,
    // one OWN cycle, then released to idle.
    align_tick();
    req_pattern[11:8] = 4'h3;
    for (int k = 0; k <= 13; k++) begin
      req = (k < 2) ? 4'b0100 : 4'b0000;
      if (k < 13) expect_next($sformatf("hold_r2_k%0d", k), 4'b0100, 1'b1, 4'h3);
      else        expect_next("release_r2", 4'b0000, 1'b0, 4'hA);
    end
    idle_cycles(4);

    // req[3] past HOLD, then req[1] preempts on the next edge.
    align_tick();
    req_pattern[15:12] = 4'h6;
    req = 4'b1000;
    for (int k = 0; k < 16; k++) begin
      expect_next($sformatf("own_r3_k%0d", k), 4'b1000, 1'b1, 4'h6);
    end
    req_pattern[7:4] = 4'hC;
    req = 4'b1010;
    expect_next("preempt_own", 4'b0010, 1'b1, 4'hC);
    req = 4'b0000;
    idle_cycles(20);

    // req[1] raised while req[3] is in HOLD: waits for the first OWN cycle.
    align_tick();
    for (int k = 0; k <= 13; k++) begin
      req = (k >= 5) ? 4'b1010 : 4'b1000;
      if (k < 13) expect_next($sformatf("preempt_wait_k%0d", k), 4'b1000, 1'b1, 4'h6);
      else        expect_next("preempt_after_hold", 4'b0010, 1'b1, 4'hC);
    end
    req = 4'b0000;
    idle_cycles(20);

    // Blink on req[0]: 8 on, 8 off; pattern changed while off shows next on.
    align_tick();
    req_pattern[3:0] = 4'hF;
    req_blink        = 4'b0001;
    req              = 4'b0001;
    for (int k = 0; k < 24; k++) begin
      if (k == 10) req_pattern[3:0] = 4'h9;
      expect_next($sformatf("blink_k%0d", k), 4'b0001, 1'b1,
                  (k < 8) ? 4'hF : ((k < 16) ? 4'h0 : 4'h9));
    end
    req       = 4'b0000;
    req_blink = 4'b0000;
    idle_cycles(20);

    // Simultaneous req[0] and req[2]; then hand off without an idle cycle.
    align_tick();
    req_pattern[3:0]  = 4'hF;
    req_pattern[11:8] = 4'h3;
    req               = 4'b0101;
    for (int k = 0; k < 16; k++) begin
      expect_next($sformatf("simul_k%0d", k), 4'b0001, 1'b1, 4'hF);
    end
    req = 4'b0100;
    expect_next("handoff", 4'b0100, 1'b1, 4'h3);
    expect_next("handoff_hold", 4'b0100, 1'b1, 4'h3);
    req = 4'b0000;
    idle_cycles(20);

    // Asynchronous reset in the off phase of a blink.
    align_tick();
    req_pattern[3:0] = 4'hF;
    req_blink        = 4'b0001;
    req              = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      expect_next($sformatf("pre_reset_k%0d", k), 4'b0001, 1'b1, (k < 8) ? 4'hF : 4'h0);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_outputs("reset_mid_blink", 4'b0000, 1'b0, 4'hA);
    @(negedge clk);
    reset = 1'b0;
    expect_next("regrant_after_reset", 4'b0001, 1'b1, 4'hF);
    req = 4'b0000;
    idle_cycles(2);

    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_status_arbiter.md
Name: led_status_arbiter

Overview:
- Shares the 4-bit front-panel LED bank between NUM_REQ status requesters: link monitor, DMA engine, error trap and similar sources.
- Fixed-priority arbiter with a minimum-hold window, so a grant cannot be taken away before the window ends and the LEDs do not flicker between owners.
- Optional per-requester blink mode.
- When no requester is active, the LEDs alternate 0xA/0x5 as the idle indication.
- Sits between the status sources and the top-level led output, in the 10 MHz clock domain after the clocking module.

Parameters:
- NUM_REQ, 4: number of requesters; index 0 has the highest priority.
- TICK_DIV, 10000: clk_10MHz cycles per tick (1 ms at 10 MHz).
- MIN_HOLD_TICKS, 500: minimum ticks a grant is held before it can be preempted.
- BLINK_HALF_TICKS, 417: ticks per blink/idle half-period (about 1.2 Hz).

Ports:
- clk_10MHz, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, NUM_REQ: request level per requester; held high while the requester wants the LEDs.
- req_pattern, input, 4*NUM_REQ: 4-bit pattern per requester; requester i uses bits [4i+3:4i].
- req_blink, input, NUM_REQ: 1 = blink that requester's pattern, 0 = show it steady.
- grant, output, NUM_REQ: one-hot current owner; all zeros when idle.
- busy, output, 1: high when any grant is active.
- led, output, 4: registered LED drive.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, may arrive mid-operation), effective immediately:
  - state = IDLE; grant = 0; busy = 0; led = 4'hA.
  - Tick prescaler, hold counter, blink counter and blink phase all cleared.
  - Latched pattern and blink flag cleared.
- Tick prescaler:
  - Counts 0..TICK_DIV-1; tick pulse is 1 cycle when count = TICK_DIV-1, then wraps to 0.
  - Free-running; never restarted by a grant.
- Counter widths: $clog2(max+1) of their terminal values. No overflow: every counter saturates or wraps only at its terminal value.
- Arbitration winner: the lowest index i with req[i] = 1.
- Latency: req sampled high at edge n gives grant, busy and led updated at edge n (visible the following cycle).
- State machine:
  - IDLE:
    - led toggles between 0xA and 0x5 each time the blink counter reaches BLINK_HALF_TICKS-1 on a tick.
    - If any req: grant the winner, latch its pattern and blink flag, clear hold counter, blink counter and phase (phase 0 = pattern shown), busy = 1, go to HOLD.
  - HOLD:
    - Hold counter increments on each tick. At MIN_HOLD_TICKS-1 on a tick, go to OWN.
    - While the owner's req = 1, pattern and blink flag re-latch every cycle.
    - If the owner's req drops, the last latched values are kept and the grant is kept until HOLD ends.
    - Preemption is ignored in HOLD.
  - OWN:
    - Checks are evaluated in this order each cycle:
      1. Owner req = 0 and another req is active: re-arbitrate, grant the winner, go to HOLD.
      2. Owner req = 0 and no req is active: grant = 0, busy = 0, led = 0xA, blink counter cleared, go to IDLE.
      3. A higher-priority req (lower index) is active: preempt, grant it, go to HOLD.
      4. Otherwise: stay in OWN, re-latching the owner's pattern every cycle.
    - Lower-priority requests wait; they are never starved once higher-priority owners release.
- LED value while granted:
  - Blink flag = 0: led = latched pattern.
  - Blink flag = 1: led = latched pattern when phase = 0, 4'h0 when phase = 1. Phase toggles every BLINK_HALF_TICKS ticks.
- Any new grant restarts hold and blink timing from zero. An owner that drops and re-raises req in the same cycle is treated as continuous.
- grant is always one-hot or zero; never more than one bit set.

Test Plan:
- Bench parameters: TICK_DIV = 4, MIN_HOLD_TICKS = 3, BLINK_HALF_TICKS = 2 for all scenarios.
- Reset then no requests:
  - Immediately after reset: led = 0xA, grant = 0, busy = 0.
  - led becomes 0x5 after 8 cycles and 0xA after 16 cycles.
- req[2] = 1, pattern 0x3, blink = 0:
  - Next edge: grant = 4'b0100, busy = 1, led = 0x3.
  - Drop req[2] after 2 cycles: grant is held through 12 cycles of HOLD, then grant = 0 and led = 0xA.
- Preemption:
  - req[3] is owner and past HOLD; raise req[1] with pattern 0xC: next edge grant = 4'b0010, led = 0xC.
  - Raise req[1] while req[3] is still in HOLD: grant stays 4'b1000 until HOLD ends, then switches to 4'b0010.
- Blink: req[0], pattern 0xF, blink = 1:
  - led = 0xF for 8 cycles, then 0x0 for 8 cycles, repeating.
  - Change the pattern to 0x9 mid-grant: the next "on" phase shows 0x9.
- Handoff and simultaneity:
  - req[0] and req[2] raised in the same cycle: grant = 4'b0001.
  - req[0] released in OWN while req[2] is still high: grant = 4'b0100 on the next edge, with no idle cycle.
- Asynchronous reset mid-blink, asserted between clock edges:
  - led = 0xA and grant = 0 immediately, without waiting for a clock edge.
  - After deassertion, a still-high req is granted on the next edge.
